idu_stage: RTL
==============

# idu_stage

Parametrised successor decode stage for the in-order core: it decodes RV32I, with optional RV32M, into the one-hot decode-info bus. It registers the ID/EX payload behind a valid/ready handshake with a two-entry skid buffer, so upstream `o_ready` is registered. It sits between the fetch/IF-ID register and the EXU, and it reports illegal instructions and exact register usage to the hazard controller.

## Interface
- `INSTR_WIDTH`, default 32: instruction width; only 32 is legal.
- `DECODE_INFO_BUS_WIDTH`, default 16: decode-info bus width; must be ≥ `OP_BITS`+3.
- `OP_BITS`, default 12: one-hot op field width.
- `M_EXT`, default 0: when 1, decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU as type MDU; when 0 they are illegal.
- `SKID_EN`, default 1: when 1, the output uses a two-entry skid buffer; when 0, a single register with combinational `o_ready`.

Ports:
- `clk_sys`  in  1  core clock; the only clock.
- `rst_sys`  in  1  reset; synchronous, active-high.
- `i_valid`  in  1  instruction present on `i_pc` and `i_instr`.
- `o_ready`  out  1  stage can accept the instruction this cycle.
- `i_pc`  in  32  PC of the instruction.
- `i_instr`  in  `INSTR_WIDTH`  raw instruction.
- `o_rs1_idx`, `o_rs2_idx`  out  5  regfile read indices; 0 when the source is unused.
- `i_rs1_data`, `i_rs2_data`  in  32  regfile read data, same cycle as the indices.
- `o_rs1_en`, `o_rs2_en`  out  1  decode-side source usage, qualified by `i_valid`.
- `i_id2ex_stall`  in  1  hazard hold; treated as downstream not-ready.
- `i_id2ex_flush`  in  1  kill all buffered and incoming instructions.
- `i_ready_e`  in  1  EXU accepts the head entry.
- `o_valid_e`  out  1  head entry valid.
- `o_pc_e`, `o_imm_e`, `o_rs1data_e`, `o_rs2data_e`  out  32  head entry payload.
- `o_rdidx_e`, `o_rs1idx_e`, `o_rs2idx_e`  out  5  head entry register indices.
- `o_rd_en`  out  1  head entry writes rd; 0 when rd = x0.
- `o_illegal_e`  out  1  head entry is an illegal instruction.
- `o_decode_info_bus`  out  `DECODE_INFO_BUS_WIDTH`  type field in the top 3 bits, one-hot op in the low bits.

## Operation
- Type codes:
  - 000: illegal or none.
  - 001: ALU.
  - 010: BJP.
  - 011: AGU.
  - 100: CSR/SYS.
  - 101: MDU (only when `M_EXT`=1).
- ALU/BJP/AGU/CSR op bit positions are fixed in the package. Bit 10 marks "immediate operand".
- MDU ops occupy bits 0–7, ordered MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Immediate selection:
  - I-imm: OP-IMM, LOAD, JALR, CSR.
  - S-imm: STORE.
  - B-imm: BRANCH.
  - U-imm: LUI, AUIPC.
  - J-imm: JAL.
  - Otherwise 0.
- The CSR zimm (`instr[19:15]`) is carried in `o_imm_e[4:0]` for CSRR*I.
- Source usage: `rs2_en` only for R-type, S-type, B-type and MDU, and `o_rs2_idx` is masked by `rs2_en`. `rs1_en` is never set for CSRR*I, LUI, AUIPC or JAL.
- Illegal is any opcode/func3/func7 combination not listed. An illegal instruction enters the pipe with type 000, `rd_en`=0, `rs_en`=0 and `o_illegal_e`=1.
- The handshake is accepted on `i_valid & o_ready`.
- Downstream readiness: `dn_rdy = i_ready_e & ~i_id2ex_stall`. The head entry retires on `o_valid_e & dn_rdy`.
- Skid buffer (`SKID_EN`=1): a main entry M and a skid entry S.
  - `o_ready` = ~S.valid, registered.
  - Accept while M is full and not retiring: the payload goes to S.
  - Retire while S is full: S moves to M the same cycle, and a new accept goes to S.
  - No state ever reaches M.valid=0 with S.valid=1.
- `SKID_EN`=0: `o_ready = ~M.valid | dn_rdy`.
- Flush: the next state is all entries invalid with the payload zeroed, and any input accepted in the flush cycle is dropped. Flush has priority over stall, accept and retire.
- Reset: all valids and payload registers are 0, `o_ready`=1, all `_e` outputs are 0 and `o_decode_info_bus`=0.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears at `o_valid_e` after edge N when the pipe is empty.
- Regfile data is sampled on the accept edge. Later writeback into buffered entries is covered by hazard forwarding on `o_rs*idx_e`.
- Throughput is 1 instruction per cycle with `dn_rdy` held high.
- After the first `dn_rdy`=0 cycle, `o_ready` drops one cycle later. No instruction is lost or duplicated.
- Payload is stable while `o_valid_e & ~dn_rdy`.
- Stall and flush in the same cycle: flush wins.
- Reset asserted mid-stream: all state is cleared on that edge.

## Structure
- Package `idu_pkg`: type codes, op bit positions per type, the `IMM_VAL` bit index, and opcode constants.
- Sub-module `idu_dec`: purely combinational decoder producing the info bus, immediate, rs/rd enables and the illegal flag. The `idu_stage` top holds the skid buffer and handshake.

## Test plan
- `add x3,x1,x2` (0x002081B3) with rs1=5, rs2=7 → next cycle type 001, ADD bit set, `o_rdidx_e`=3, `o_rs1data_e`=5, `o_rs2data_e`=7, `o_rd_en`=1.
- `mul x5,x6,x7` (0x027302B3): with `M_EXT`=0 → `o_illegal_e`=1, type 000, `o_rd_en`=0; with `M_EXT`=1 → type 101, bit 0 set.
- Stream of 4 instructions with `i_ready_e`=0 from cycle 2 → M and S fill, `o_ready`=0. Release → all 4 retire in order, with no loss or duplication.
- `i_id2ex_flush` with both entries full and `i_valid`=1 → next cycle `o_valid_e`=0, `o_ready`=1, and the incoming instruction is not delivered.
- `csrrwi x1,mstatus,5` → `o_rs1_en`=0, `o_rs1_idx`=0, `o_imm_e[4:0]`=5. `addi x0,x0,0` → `o_rd_en`=0.
- Reset asserted for 1 cycle during backpressure → all outputs 0 and `o_ready`=1 on the following cycle.

Source files
------------

// File: rtl/idu_pkg.sv
// Shared decode constants and the ID/EX payload bundle.
// Op fields are one-hot bit positions inside the decode-info bus.
package idu_pkg;

   localparam logic [2:0] TY_NONE = 3'b000;
   localparam logic [2:0] TY_ALU  = 3'b001;
   localparam logic [2:0] TY_BJP  = 3'b010;
   localparam logic [2:0] TY_AGU  = 3'b011;
   localparam logic [2:0] TY_CSR  = 3'b100;
   localparam logic [2:0] TY_MDU  = 3'b101;

   localparam logic [3:0] IMM_VAL = 4'd10;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_XOR  = 4'd2;
   localparam logic [3:0] ALU_SLL  = 4'd3;
   localparam logic [3:0] ALU_SRL  = 4'd4;
   localparam logic [3:0] ALU_SRA  = 4'd5;
   localparam logic [3:0] ALU_OR   = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;
   localparam logic [3:0] ALU_LUI  = 4'd11;

   localparam logic [3:0] BJP_JAL   = 4'd0;
   localparam logic [3:0] BJP_JALR  = 4'd1;
   localparam logic [3:0] BJP_BEQ   = 4'd2;
   localparam logic [3:0] BJP_AUIPC = 4'd8;

   localparam logic [3:0] AGU_LB = 4'd0;
   localparam logic [3:0] AGU_LH = 4'd1;
   localparam logic [3:0] AGU_LW = 4'd2;
   localparam logic [3:0] AGU_LBU = 4'd3;
   localparam logic [3:0] AGU_LHU = 4'd4;
   localparam logic [3:0] AGU_SB = 4'd5;

   localparam logic [3:0] CSR_RW     = 4'd0;
   localparam logic [3:0] SYS_ECALL  = 4'd3;
   localparam logic [3:0] SYS_EBREAK = 4'd4;
   localparam logic [3:0] SYS_MRET   = 4'd5;
   localparam logic [3:0] SYS_FENCE  = 4'd6;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] rs1data;
      logic [31:0] rs2data;
      logic [4:0]  rdidx;
      logic [4:0]  rs1idx;
      logic [4:0]  rs2idx;
      logic        rd_en;
      logic        illegal;
      logic [2:0]  typ;
   } id_ex_t;

   function automatic logic [3:0] alu_sel(input logic [2:0] f3);
      logic [3:0] s;
      case (f3)
         3'd0:    s = ALU_ADD;
         3'd1:    s = ALU_SLL;
         3'd2:    s = ALU_SLT;
         3'd3:    s = ALU_SLTU;
         3'd4:    s = ALU_XOR;
         3'd5:    s = ALU_SRL;
         3'd6:    s = ALU_OR;
         default: s = ALU_AND;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/idu_dec.sv
// Combinational RV32I(+M) decoder: type, one-hot op, immediate,
// register usage and the illegal flag.
module idu_dec
   import idu_pkg::*;
#(
   parameter int OP_BITS = 12,
   parameter bit M_EXT   = 1'b0
) (
   input  logic [31:0]        instr,
   output logic [2:0]         typ,
   output logic [OP_BITS-1:0] op,
   output logic [31:0]        imm,
   output logic               rd_en,
   output logic               rs1_en,
   output logic               rs2_en,
   output logic               illegal
);

   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [4:0]  rd;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
   logic        ok, use_imm, wr, r1, r2;
   logic [3:0]  sel;
   logic [2:0]  ty;
   logic [31:0] im;

   assign opc   = instr[6:0];
   assign rd    = instr[11:7];
   assign f3    = instr[14:12];
   assign f7    = instr[31:25];
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'd0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                   instr[20], instr[30:21], 1'b0};
   // CSR address stays in the top bits, zimm rides in [4:0]
   assign imm_z = {instr[31:20], 15'd0, instr[19:15]};

   always_comb begin
      ok = 1'b0; use_imm = 1'b0; wr = 1'b0;
      r1 = 1'b0; r2 = 1'b0;
      sel = '0; ty = TY_NONE; im = '0;
      unique case (opc)
         OPC_LUI: begin
            ok = 1'b1; ty = TY_ALU; sel = ALU_LUI;
            use_imm = 1'b1; wr = 1'b1; im = imm_u;
         end
         OPC_AUIPC: begin
            ok = 1'b1; ty = TY_BJP; sel = BJP_AUIPC;
            use_imm = 1'b1; wr = 1'b1; im = imm_u;
         end
         OPC_JAL: begin
            ok = 1'b1; ty = TY_BJP; sel = BJP_JAL;
            wr = 1'b1; im = imm_j;
         end
         OPC_JALR: begin
            ok = (f3 == 3'd0); ty = TY_BJP; sel = BJP_JALR;
            use_imm = 1'b1; wr = 1'b1; r1 = 1'b1; im = imm_i;
         end
         OPC_BRANCH: begin
            ok = (f3 != 3'd2) && (f3 != 3'd3);
            ty = TY_BJP; r1 = 1'b1; r2 = 1'b1; im = imm_b;
            sel = (f3[2]) ? {1'b0, f3} : BJP_BEQ + {3'd0, f3[0]};
         end
         OPC_LOAD: begin
            ty = TY_AGU; use_imm = 1'b1; wr = 1'b1;
            r1 = 1'b1; im = imm_i; ok = 1'b1;
            case (f3)
               3'd0:    sel = AGU_LB;
               3'd1:    sel = AGU_LH;
               3'd2:    sel = AGU_LW;
               3'd4:    sel = AGU_LBU;
               3'd5:    sel = AGU_LHU;
               default: ok = 1'b0;
            endcase
         end
         OPC_STORE: begin
            ok = (f3 < 3'd3); ty = TY_AGU; use_imm = 1'b1;
            r1 = 1'b1; r2 = 1'b1; im = imm_s;
            sel = AGU_SB + {2'd0, f3[1:0]};
         end
         OPC_OPIMM: begin
            ty = TY_ALU; use_imm = 1'b1; wr = 1'b1;
            r1 = 1'b1; im = imm_i; ok = 1'b1;
            sel = alu_sel(f3);
            if (f3 == 3'd1) ok = (f7 == 7'h00);
            if (f3 == 3'd5) begin
               ok = (f7 == 7'h00) || (f7 == 7'h20);
               sel = f7[5] ? ALU_SRA : ALU_SRL;
            end
         end
         OPC_OP: begin
            ty = TY_ALU; wr = 1'b1; r1 = 1'b1; r2 = 1'b1;
            if (f7 == 7'h00) begin
               ok = 1'b1; sel = alu_sel(f3);
            end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
               ok = 1'b1; sel = f3[2] ? ALU_SRA : ALU_SUB;
            end else if (f7 == 7'h01 && M_EXT) begin
               ok = 1'b1; ty = TY_MDU; sel = {1'b0, f3};
            end
         end
         OPC_FENCE: begin
            ok = (f3 == 3'd0); ty = TY_CSR; sel = SYS_FENCE;
         end
         OPC_SYSTEM: begin
            ty = TY_CSR; im = imm_i;
            sel = CSR_RW + {2'd0, f3[1:0] - 2'd1};
            if (f3 == 3'd0) begin
               ok = 1'b1;
               if (instr == 32'h0000_0073) sel = SYS_ECALL;
               else if (instr == 32'h0010_0073) sel = SYS_EBREAK;
               else if (instr == 32'h3020_0073) sel = SYS_MRET;
               else ok = 1'b0;
            end else if (f3[1:0] != 2'd0) begin
               ok = 1'b1; wr = 1'b1;
               r1 = ~f3[2];
               use_imm = f3[2];
               if (f3[2]) im = imm_z;
            end
         end
         default: ok = 1'b0;
      endcase
   end

   always_comb begin
      op = '0;
      if (ok) begin
         op[sel] = 1'b1;
         op[IMM_VAL] = use_imm;
      end
   end

   assign typ     = ok ? ty : TY_NONE;
   assign imm     = ok ? im : 32'd0;
   assign rd_en   = ok & wr & (rd != 5'd0);
   assign rs1_en  = ok & r1;
   assign rs2_en  = ok & r2;
   assign illegal = ~ok;

endmodule

// File: rtl/idu_stage.sv
// Decode stage: decoder plus ID/EX register with a two-entry skid
// buffer so that upstream ready comes straight from a flop.
module idu_stage
   import idu_pkg::*;
#(
   parameter int INSTR_WIDTH           = 32,
   parameter int DECODE_INFO_BUS_WIDTH = 16,
   parameter int OP_BITS               = 12,
   parameter bit M_EXT                 = 1'b0,
   parameter bit SKID_EN               = 1'b1
) (
   input  logic                             clk_sys,
   input  logic                             rst_sys,
   input  logic                             i_valid,
   output logic                             o_ready,
   input  logic [31:0]                      i_pc,
   input  logic [INSTR_WIDTH-1:0]           i_instr,
   output logic [4:0]                       o_rs1_idx,
   output logic [4:0]                       o_rs2_idx,
   input  logic [31:0]                      i_rs1_data,
   input  logic [31:0]                      i_rs2_data,
   output logic                             o_rs1_en,
   output logic                             o_rs2_en,
   input  logic                             i_id2ex_stall,
   input  logic                             i_id2ex_flush,
   input  logic                             i_ready_e,
   output logic                             o_valid_e,
   output logic [31:0]                      o_pc_e,
   output logic [31:0]                      o_imm_e,
   output logic [31:0]                      o_rs1data_e,
   output logic [31:0]                      o_rs2data_e,
   output logic [4:0]                       o_rdidx_e,
   output logic [4:0]                       o_rs1idx_e,
   output logic [4:0]                       o_rs2idx_e,
   output logic                             o_rd_en,
   output logic                             o_illegal_e,
   output logic [DECODE_INFO_BUS_WIDTH-1:0] o_decode_info_bus
);

   logic [2:0]         d_typ;
   logic [OP_BITS-1:0] d_op;
   logic [31:0]        d_imm;
   logic               d_rd_en, d_rs1_en, d_rs2_en, d_ill;

   idu_dec #(.OP_BITS(OP_BITS), .M_EXT(M_EXT)) u_dec (
      .instr   (i_instr[31:0]),
      .typ     (d_typ),
      .op      (d_op),
      .imm     (d_imm),
      .rd_en   (d_rd_en),
      .rs1_en  (d_rs1_en),
      .rs2_en  (d_rs2_en),
      .illegal (d_ill)
   );

   assign o_rs1_idx = d_rs1_en ? i_instr[19:15] : 5'd0;
   assign o_rs2_idx = d_rs2_en ? i_instr[24:20] : 5'd0;
   assign o_rs1_en  = i_valid & d_rs1_en;
   assign o_rs2_en  = i_valid & d_rs2_en;

   id_ex_t             m_q, s_q, new_e;
   logic [OP_BITS-1:0] m_op, s_op;
   logic               m_v, s_v, dn_rdy, acc, ret;

   assign new_e = '{pc: i_pc, imm: d_imm,
                    rs1data: i_rs1_data, rs2data: i_rs2_data,
                    rdidx: i_instr[11:7],
                    rs1idx: o_rs1_idx, rs2idx: o_rs2_idx,
                    rd_en: d_rd_en, illegal: d_ill, typ: d_typ};

   assign dn_rdy  = i_ready_e & ~i_id2ex_stall;
   assign ret     = m_v & dn_rdy;
   assign o_ready = SKID_EN ? ~s_v : (~m_v | dn_rdy);
   assign acc     = i_valid & o_ready;

   // S only fills while M is held, so M.valid=0 with S.valid=1 never occurs
   always_ff @(posedge clk_sys) begin
      if (rst_sys || i_id2ex_flush) begin
         m_v  <= 1'b0;
         s_v  <= 1'b0;
         m_q  <= '0;
         s_q  <= '0;
         m_op <= '0;
         s_op <= '0;
      end else if (ret) begin
         if (s_v) begin
            m_q  <= s_q;
            m_op <= s_op;
            s_v  <= acc;
            if (acc) begin
               s_q  <= new_e;
               s_op <= d_op;
            end
         end else begin
            m_v <= acc;
            if (acc) begin
               m_q  <= new_e;
               m_op <= d_op;
            end
         end
      end else if (acc) begin
         if (m_v) begin
            s_v  <= 1'b1;
            s_q  <= new_e;
            s_op <= d_op;
         end else begin
            m_v  <= 1'b1;
            m_q  <= new_e;
            m_op <= d_op;
         end
      end
   end

   assign o_valid_e   = m_v;
   assign o_pc_e      = m_q.pc;
   assign o_imm_e     = m_q.imm;
   assign o_rs1data_e = m_q.rs1data;
   assign o_rs2data_e = m_q.rs2data;
   assign o_rdidx_e   = m_q.rdidx;
   assign o_rs1idx_e  = m_q.rs1idx;
   assign o_rs2idx_e  = m_q.rs2idx;
   assign o_rd_en     = m_q.rd_en;
   assign o_illegal_e = m_q.illegal;

   always_comb begin
      o_decode_info_bus = '0;
      o_decode_info_bus[DECODE_INFO_BUS_WIDTH-1 -: 3] = m_q.typ;
      o_decode_info_bus[OP_BITS-1:0] = m_op;
   end

endmodule
